// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: per-timestep controller for the shared neuron-update
// datapath. Latches spike requests into a pending register and grants them
// one at a time in round-robin order over a valid/ready handshake. It then
// issues a single leak command and pulses step_done.
// Optional feature: define SPIKE_DROP_COUNT_EN to build the saturating
// dropped-spike counter; otherwise drop_count is tied to zero.
module spike_event_arbiter #(
   parameter int NUM_REQ = 8,
   parameter int ADDR_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic               step_start,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_addr,
   input  logic               out_ready,
   output logic               leak_valid,
   input  logic               leak_ready,
   output logic               step_done,
   output logic               busy,
   output logic [NUM_REQ-1:0] pending,
   output logic [7:0]         drop_count
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      LEAK,
      DONE
   } state_e;

   state_e              state_q, state_d;

   logic [NUM_REQ-1:0]  pending_q, pending_d;
   logic [NUM_REQ-1:0]  clear_mask;
   logic [NUM_REQ-1:0]  req_eff;
   logic [ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]   hs_ptr;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                leak_valid_q, leak_valid_d;
   logic                grant_hs;
   logic                leak_hs;

   // First set bit of vec, searching upward from ptr and wrapping at NUM_REQ-1.
   // The vector is rotated so that bit 0 corresponds to ptr; the found offset
   // is then mapped back to an absolute index.
   function automatic logic [ADDR_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0] vec,
      input logic [ADDR_W-1:0]  ptr
   );
      logic [NUM_REQ-1:0] rot;
      logic               found;
      int unsigned        idx;
      logic [ADDR_W-1:0]  sel;
      rot   = NUM_REQ'({vec, vec} >> ptr);
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            idx   = 32'(ptr) + i;
            if (idx >= 32'(NUM_REQ)) begin
               idx = idx - 32'(NUM_REQ);
            end
            sel = ADDR_W'(idx);
         end
      end
      return sel;
   endfunction

   assign grant_hs = out_valid_q && out_ready;
   assign leak_hs  = leak_valid_q && leak_ready;

   // Pointer just past the address being handshaked, wrapping to 0
   assign hs_ptr = (out_addr_q == ADDR_W'(NUM_REQ - 1)) ? '0 : out_addr_q + ADDR_W'(1);

   // Pending update: clear the granted bit, then OR in new requests (set wins)
   always_comb begin
      req_eff = en ? req_in : '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         clear_mask[i] = grant_hs && (out_addr_q == ADDR_W'(i));
      end
      pending_d = (pending_q & ~clear_mask) | req_eff;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (step_start && en) begin
               state_d = (pending_q != '0) ? DRAIN : LEAK;
            end
         end
         DRAIN: begin
            if ((!out_valid_q || grant_hs) && (pending_d == '0)) begin
               state_d = LEAK;
            end
         end
         LEAK: begin
            if (leak_hs) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered grant/leak outputs and rr pointer.
   // A new grant is chosen from pending_d whenever the slot is empty or just
   // handshaked, so grants run back-to-back while out_ready stays high.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_addr_d   = out_addr_q;
      leak_valid_d = leak_valid_q;
      rr_ptr_d     = rr_ptr_q;
      case (state_q)
         DRAIN: begin
            leak_valid_d = 1'b0;
            if (grant_hs) begin
               rr_ptr_d = hs_ptr;
            end
            if (!out_valid_q || grant_hs) begin
               if (pending_d != '0) begin
                  out_valid_d = 1'b1;
                  out_addr_d  = rr_pick(pending_d, grant_hs ? hs_ptr : rr_ptr_q);
               end else begin
                  out_valid_d = 1'b0;
               end
            end
         end
         LEAK: begin
            out_valid_d = 1'b0;
            if (!leak_valid_q) begin
               leak_valid_d = 1'b1;
            end else if (leak_ready) begin
               leak_valid_d = 1'b0;
            end
         end
         default: begin
            out_valid_d  = 1'b0;
            leak_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers: pending set, rr pointer and handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q    <= '0;
         rr_ptr_q     <= '0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         leak_valid_q <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         rr_ptr_q     <= rr_ptr_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         leak_valid_q <= leak_valid_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_addr   = out_addr_q;
   assign leak_valid = leak_valid_q;
   assign step_done  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign pending    = pending_q;

`ifdef SPIKE_DROP_COUNT_EN
   logic [NUM_REQ-1:0] drop_bits;
   logic [31:0]        drop_sum;
   logic [7:0]         drop_count_q, drop_count_d;

   // Count requests that hit an already-pending bit which is not being cleared
   always_comb begin
      drop_bits = req_eff & pending_q & ~clear_mask;
      drop_sum  = 32'(drop_count_q);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         drop_sum = drop_sum + 32'(drop_bits[i]);
      end
      drop_count_d = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
   end

   // Saturating drop counter, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_count_q <= '0;
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign drop_count = drop_count_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Self-checking bench for spike_event_arbiter: a directed vector table,
// hand-written corner-case sequences and a randomized run, all compared
// against a cycle-level reference model of the timestep behaviour.
module tb_spike_event_arbiter;

   localparam int N  = 8;
   localparam int AW = 3;
`ifdef SPIKE_DROP_COUNT_EN
   localparam int DROP_MAX = 255;
`else
   localparam int DROP_MAX = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  req_in;
   logic          step_start;
   logic          out_valid;
   logic [AW-1:0] out_addr;
   logic          out_ready;
   logic          leak_valid;
   logic          leak_ready;
   logic          step_done;
   logic          busy;
   logic [N-1:0]  pending;
   logic [7:0]    drop_count;

   int total = 0;
   int bad   = 0;

   spike_event_arbiter #(
      .NUM_REQ(N),
      .ADDR_W (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_in    (req_in),
      .step_start(step_start),
      .out_valid (out_valid),
      .out_addr  (out_addr),
      .out_ready (out_ready),
      .leak_valid(leak_valid),
      .leak_ready(leak_ready),
      .step_done (step_done),
      .busy      (busy),
      .pending   (pending),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_DRAIN, M_LEAK, M_DONE} mphase_e;
   mphase_e      m_phase;
   logic [N-1:0] m_pend;
   int           m_rr;
   bit           m_gv;
   int           m_ga;
   bit           m_lv;
   int           m_drop;

   function automatic int rr_first(input logic [N-1:0] p, input int from);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (from + k) % N;
         if (p[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE;
      m_pend  = '0;
      m_rr    = 0;
      m_gv    = 0;
      m_ga    = 0;
      m_lv    = 0;
      m_drop  = 0;
   endtask

   task automatic model_step(input logic e, input logic [N-1:0] r, input logic ss,
                             input logic ordy, input logic lrdy);
      logic [N-1:0] nxt;
      bit           ghs;
      int           dropped;
      ghs     = m_gv && ordy;
      nxt     = m_pend;
      dropped = 0;
      if (ghs) nxt[m_ga] = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (e && r[j]) begin
            if (nxt[j]) dropped++;
            nxt[j] = 1'b1;
         end
      end
`ifdef SPIKE_DROP_COUNT_EN
      m_drop = (m_drop + dropped > 255) ? 255 : m_drop + dropped;
`endif
      case (m_phase)
         M_IDLE:  if (ss && e) m_phase = (m_pend != 0) ? M_DRAIN : M_LEAK;
         M_DRAIN: begin
            if (!m_gv || ghs) begin
               if (ghs) m_rr = (m_ga + 1) % N;
               if (nxt != 0) begin
                  m_gv = 1;
                  m_ga = rr_first(nxt, m_rr);
               end else begin
                  m_gv    = 0;
                  m_phase = M_LEAK;
               end
            end
         end
         M_LEAK: begin
            if (!m_lv) m_lv = 1;
            else if (lrdy) begin
               m_lv    = 0;
               m_phase = M_DONE;
            end
         end
         default: m_phase = M_IDLE;
      endcase
      m_pend = nxt;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("pending", 32'(pending), 32'(m_pend));
      chk("out_valid", 32'(out_valid), 32'(m_gv));
      if (m_gv) chk("out_addr", 32'(out_addr), 32'(m_ga));
      chk("leak_valid", 32'(leak_valid), 32'(m_lv));
      chk("step_done", 32'(step_done), 32'(m_phase == M_DONE));
      chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("exclusive", 32'(out_valid && leak_valid), 32'(0));
   endtask

   // One clock cycle: drive inputs, advance model, sample after the edge
   task automatic cyc(input logic e, input logic [N-1:0] r, input logic ss,
                      input logic ordy, input logic lrdy);
      en         = e;
      req_in     = r;
      step_start = ss;
      out_ready  = ordy;
      leak_ready = lrdy;
      model_step(e, r, ss, ordy, lrdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int n);
      rst_n      = 1'b0;
      en         = 1'b0;
      req_in     = '0;
      step_start = 1'b0;
      out_ready  = 1'b0;
      leak_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      model_reset();
      rst_n = 1'b1;
      compare_all();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          e;
      logic [N-1:0]  req;
      logic          ss;
      logic          ov;
      logic [AW-1:0] addr;
      logic          lv;
      logic          sd;
      logic          bsy;
      logic [N-1:0]  pend;
   } vec_t;

   function automatic vec_t mk(input logic [N-1:0] req, input logic ss, input logic ov,
                               input logic [AW-1:0] addr, input logic lv, input logic sd,
                               input logic bsy, input logic [N-1:0] pend);
      vec_t v;
      v.e    = 1'b1;
      v.req  = req;
      v.ss   = ss;
      v.ov   = ov;
      v.addr = addr;
      v.lv   = lv;
      v.sd   = sd;
      v.bsy  = bsy;
      v.pend = pend;
      return v;
   endfunction

   vec_t tbl[17];

   initial begin
      // Round-robin step 2,4,7 then a second step 0,7 (pointer wrapped to 0)
      tbl[0]  = mk(8'h94, 0, 0, 0, 0, 0, 0, 8'h94);
      tbl[1]  = mk(8'h00, 1, 0, 0, 0, 0, 1, 8'h94);
      tbl[2]  = mk(8'h00, 0, 1, 2, 0, 0, 1, 8'h94);
      tbl[3]  = mk(8'h00, 0, 1, 4, 0, 0, 1, 8'h90);
      tbl[4]  = mk(8'h00, 0, 1, 7, 0, 0, 1, 8'h80);
      tbl[5]  = mk(8'h00, 0, 0, 0, 0, 0, 1, 8'h00);
      tbl[6]  = mk(8'h00, 0, 0, 0, 1, 0, 1, 8'h00);
      tbl[7]  = mk(8'h00, 0, 0, 0, 0, 1, 1, 8'h00);
      tbl[8]  = mk(8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
      tbl[9]  = mk(8'h81, 0, 0, 0, 0, 0, 0, 8'h81);
      tbl[10] = mk(8'h00, 1, 0, 0, 0, 0, 1, 8'h81);
      tbl[11] = mk(8'h00, 0, 1, 0, 0, 0, 1, 8'h81);
      tbl[12] = mk(8'h00, 0, 1, 7, 0, 0, 1, 8'h80);
      tbl[13] = mk(8'h00, 0, 0, 0, 0, 0, 1, 8'h00);
      tbl[14] = mk(8'h00, 0, 0, 0, 1, 0, 1, 8'h00);
      tbl[15] = mk(8'h00, 0, 0, 0, 0, 1, 1, 8'h00);
      tbl[16] = mk(8'h00, 0, 0, 0, 0, 0, 0, 8'h00);

      do_reset(2);
      for (int i = 0; i < 17; i++) begin
         en         = tbl[i].e;
         req_in     = tbl[i].req;
         step_start = tbl[i].ss;
         out_ready  = 1'b1;
         leak_ready = 1'b1;
         model_step(tbl[i].e, tbl[i].req, tbl[i].ss, 1'b1, 1'b1);
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) chk($sformatf("tbl%0d_addr", i), 32'(out_addr), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d_leak", i), 32'(leak_valid), 32'(tbl[i].lv));
         chk($sformatf("tbl%0d_done", i), 32'(step_done), 32'(tbl[i].sd));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
      end

      // Reset held 2 cycles mid-DRAIN with a grant outstanding
      do_reset(2);
      cyc(1, 8'h30, 0, 0, 0);
      cyc(1, 8'h00, 1, 0, 0);
      cyc(1, 8'h00, 0, 0, 0);
      chk("pre_reset_valid", 32'(out_valid), 32'(1));
      chk("pre_reset_addr", 32'(out_addr), 32'(4));
      rst_n = 1'b0;
      en    = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_valid", 32'(out_valid), 32'(0));
      chk("reset_pending", 32'(pending), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      compare_all();
      cyc(1, 8'h00, 0, 0, 0);
      chk("after_reset_busy", 32'(busy), 32'(0));

      // Backpressure: grant 1 held across 4 stalled cycles, then 1,2,0
      do_reset(2);
      cyc(1, 8'h06, 0, 0, 0);
      cyc(1, 8'h00, 1, 0, 0);
      cyc(1, 8'h00, 0, 0, 0);
      chk("bp_first", 32'(out_addr), 32'(1));
      cyc(1, 8'h01, 0, 0, 0);
      chk("bp_stall1", 32'(out_addr), 32'(1));
      cyc(1, 8'h00, 0, 0, 0);
      chk("bp_stall2", 32'(out_addr), 32'(1));
      cyc(1, 8'h00, 0, 0, 0);
      chk("bp_stall3", 32'(out_addr), 32'(1));
      cyc(1, 8'h00, 0, 0, 0);
      chk("bp_stall4", 32'(out_addr), 32'(1));
      chk("bp_stall_valid", 32'(out_valid), 32'(1));
      chk("bp_pending", 32'(pending), 32'(8'h07));
      cyc(1, 8'h00, 0, 1, 1);
      chk("bp_second", 32'(out_addr), 32'(2));
      cyc(1, 8'h00, 0, 1, 1);
      chk("bp_third", 32'(out_addr), 32'(0));
      cyc(1, 8'h00, 0, 1, 1);
      chk("bp_drained", 32'(out_valid), 32'(0));
      repeat (3) cyc(1, 8'h00, 0, 1, 1);

      // Empty step, delayed leak_ready, step_start during LEAK ignored
      cyc(1, 8'h00, 1, 0, 0);
      chk("empty_enter_busy", 32'(busy), 32'(1));
      chk("empty_enter_leak", 32'(leak_valid), 32'(0));
      cyc(1, 8'h00, 0, 0, 0);
      chk("empty_leak_up", 32'(leak_valid), 32'(1));
      cyc(1, 8'h00, 1, 0, 0);
      cyc(1, 8'h00, 0, 0, 0);
      cyc(1, 8'h00, 0, 0, 0);
      chk("empty_leak_held", 32'(leak_valid), 32'(1));
      cyc(1, 8'h00, 0, 0, 1);
      chk("empty_done", 32'(step_done), 32'(1));
      chk("empty_leak_down", 32'(leak_valid), 32'(0));
      cyc(1, 8'h00, 0, 0, 0);
      chk("empty_done_one", 32'(step_done), 32'(0));
      cyc(1, 8'h00, 0, 0, 0);
      chk("no_second_step", 32'(busy), 32'(0));

      // Set-wins collision on bit 3
      do_reset(2);
      cyc(1, 8'h18, 0, 1, 1);
      cyc(1, 8'h00, 1, 1, 1);
      cyc(1, 8'h00, 0, 1, 1);
      chk("sw_first", 32'(out_addr), 32'(3));
      cyc(1, 8'h08, 0, 1, 1);
      chk("sw_pending", 32'(pending), 32'(8'h18));
      chk("sw_next", 32'(out_addr), 32'(4));
      cyc(1, 8'h00, 0, 1, 1);
      chk("sw_regrant", 32'(out_addr), 32'(3));
      cyc(1, 8'h00, 0, 1, 1);
      chk("sw_empty", 32'(pending), 32'(0));
      repeat (3) cyc(1, 8'h00, 0, 1, 1);

      // en=0 ignores requests and ticks; drop counter saturation
      do_reset(2);
      repeat (5) cyc(0, 8'h01, 1, 1, 1);
      chk("en0_pending", 32'(pending), 32'(0));
      chk("en0_busy", 32'(busy), 32'(0));
      chk("en0_drop", 32'(drop_count), 32'(0));
      repeat (300) cyc(1, 8'h01, 0, 1, 1);
      chk("drop_sat", 32'(drop_count), 32'(DROP_MAX));
      repeat (5) cyc(0, 8'h01, 0, 1, 1);
      chk("drop_hold", 32'(drop_count), 32'(DROP_MAX));

      // Randomized run against the model
      do_reset(2);
      for (int c = 0; c < 3000; c++) begin
         logic         e, ss, ordy, lrdy;
         logic [N-1:0] r;
         e = ($urandom % 10) != 0;
         r = '0;
         if (($urandom % 3) == 0) r[$urandom_range(N - 1, 0)] = 1'b1;
         if (($urandom % 16) == 0) r[$urandom_range(N - 1, 0)] = 1'b1;
         ss   = ($urandom % 8) == 0;
         ordy = ($urandom % 5) < 3;
         lrdy = ($urandom % 2) == 0;
         cyc(e, r, ss, ordy, lrdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spike_event_arbiter.md
Name: spike_event_arbiter

Overview:
- Per-timestep controller for the neurocore's single shared neuron-update datapath.
- Latches spike requests from up to NUM_REQ input lines into a pending register.
- On each timestep, grants pending requests one at a time, in round-robin order, to the datapath over a valid/ready handshake.
- Then issues one leak command, and signals step completion.

Parameters:
- NUM_REQ, 8, number of spike request lines. Must be at least 2.
- ADDR_W, 3, width of the granted address. Must satisfy 2**ADDR_W >= NUM_REQ.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  enable. When low, req_in and step_start are ignored. FSM and handshake outputs continue.
- req_in  input  NUM_REQ  spike request pulses, one bit per source, sampled every cycle
- step_start  input  1  timestep tick, single-cycle pulse
- out_valid  output  1  grant valid to datapath
- out_addr  output  ADDR_W  index of the granted source
- out_ready  input  1  datapath accepts the grant
- leak_valid  output  1  leak command to datapath
- leak_ready  input  1  datapath accepts the leak
- step_done  output  1  one-cycle pulse when the timestep completes
- busy  output  1  high whenever state is not IDLE
- pending  output  NUM_REQ  current pending register
- drop_count  output  8  dropped-spike counter (optional feature)

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge.
  - State returns to IDLE. pending, rr_ptr, out_valid, out_addr, leak_valid, step_done and drop_count all go to 0.
  - An in-flight grant or leak is abandoned.
- Pending update, each cycle:
  - pending_next = (pending & ~clear_mask) | (en ? req_in : 0).
  - clear_mask is the one-hot of out_addr when out_valid && out_ready.
  - A set and a clear of the same bit in the same cycle resolves to set: the new spike stays pending.
- FSM states: IDLE, DRAIN, LEAK, DONE.
  - IDLE:
    - step_start && en with pending != 0 -> DRAIN.
    - step_start && en with pending == 0 -> LEAK.
    - step_start in any other state is ignored.
  - DRAIN:
    - Registered grant logic. out_valid rises the cycle after entry.
    - Selected index = first set bit of the effective pending, searching upward from rr_ptr with wrap-around from NUM_REQ-1 to 0.
    - While out_valid && !out_ready, out_valid and out_addr are held stable, even if new requests arrive.
    - On handshake: rr_ptr <= out_addr+1, wrapping to 0 after NUM_REQ-1. The next grant is computed from pending_next, giving back-to-back grants with 1 grant/cycle throughput while out_ready=1.
    - If pending_next == 0 on a handshake, out_valid drops and the state goes to LEAK.
    - Requests arriving during DRAIN are served in the same timestep.
  - LEAK:
    - leak_valid=1 starting the cycle after entry, held until leak_ready.
    - On handshake: leak_valid drops and the state goes to DONE.
    - Requests arriving during LEAK stay pending for the next step.
  - DONE:
    - step_done=1 for exactly one cycle, then -> IDLE.
- Exclusivity: out_valid and leak_valid are never high together.
- Minimum timestep length: 3 cycles for an empty step with leak_ready tied high.

Optional Feature:
- Macro: SPIKE_DROP_COUNT_EN.
- Defined:
  - drop_count increments by the number of req_in bits that are set while en=1 and whose pending bit is already set and not being cleared that cycle.
  - Increments are summed within a cycle.
  - Saturates at 255. Cleared only by reset.
- Undefined: drop_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-DRAIN with out_valid=1 -> next cycle out_valid=0, pending=0, busy=0, state IDLE.
- Round-robin order: req_in=8'b1001_0100 in IDLE, step_start, out_ready=1 -> out_addr sequence 2,4,7 on consecutive cycles, then leak_valid=1, leak_ready=1 -> step_done pulse; rr_ptr=0 (wrapped). Next step with req_in=8'h81 -> order 0,7.
- Backpressure: pending=8'h06, out_ready=0 for 4 cycles, req_in=8'h01 pulsed during the stall -> out_addr stays 1 for all 4 cycles. After release, order is 1,2,0 (rr_ptr=2 after granting 1).
- Empty step and ignored ticks: pending=0, step_start -> leak_valid the cycle after. leak_ready delayed 3 cycles -> step_done 1 cycle after the leak handshake. A step_start pulsed during LEAK -> no second step.
- Set-wins collision: out_addr=3 handshaking in the same cycle as req_in[3]=1 -> pending[3] remains 1 and is granted again later in the same DRAIN.
- With SPIKE_DROP_COUNT_EN: req_in=8'h01 on 300 consecutive cycles in IDLE with en=1 -> drop_count=255. With en=0 -> no change.
